// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// alu_pipe: registered ALU with valid/ready handshake on both sides.
// Single-cycle logic/arith ops complete one edge after acceptance; the
// optional shift-add multiply holds the block busy for WIDTH edges.
module alu_pipe #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [2:0]       funSel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic             zeroFlag,
   output logic             carryFlag,
   output logic             ovfFlag,
   output logic             negFlag
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     cnt;

   logic                 accept;
   logic                 is_mul;
   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       diff_ext;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_carry;
   logic                 alu_ovf;
   logic [2*WIDTH-1:0]   acc_step;
   logic [WIDTH-1:0]     ld_res;
   logic                 ld_carry;
   logic                 ld_ovf;

   // Offer is taken only when idle and the output slot is free or draining.
   assign inReady = rstN & (state == IDLE) & (~outValid | outReady);
   assign accept  = inValid & inReady;
   assign is_mul  = MUL_EN && (funSel == 3'b110);

   // Extended add/subtract: bit WIDTH is carry-out for ADD and borrow for SUB.
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};

   // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
   assign acc_step = acc + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});

   // Single-cycle operation results and their carry/overflow flags.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (funSel)
         3'b000: alu_res = a & b;
         3'b001: alu_res = a | b;
         3'b010: begin
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_ext[WIDTH-1] != a[WIDTH-1]);
         end
         3'b011: begin
            alu_res   = diff_ext[WIDTH-1:0];
            alu_carry = diff_ext[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (diff_ext[WIDTH-1] != a[WIDTH-1]);
         end
         3'b100: alu_res = a ^ b;
         3'b101: alu_res = ~(a | b);
         3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: alu_res = '0;  // 110 without multiplier returns zero
      endcase
   end

   // Select what the output register loads: the final multiply step while busy,
   // otherwise the single-cycle result.
   always_comb begin
      ld_res   = alu_res;
      ld_carry = alu_carry;
      ld_ovf   = alu_ovf;
      if (state == BUSY) begin
         ld_res   = acc_step[WIDTH-1:0];
         ld_carry = 1'b0;
         ld_ovf   = |acc_step[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM, multiplier datapath and output register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         mcand     <= '0;
         acc       <= '0;
         mplier    <= '0;
         cnt       <= '0;
         outValid  <= 1'b0;
         result    <= '0;
         zeroFlag  <= 1'b0;
         carryFlag <= 1'b0;
         ovfFlag   <= 1'b0;
         negFlag   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     mcand    <= {{WIDTH{1'b0}}, a};
                     mplier   <= b;
                     acc      <= '0;
                     cnt      <= CNT_W'(WIDTH);
                     state    <= BUSY;
                     // any pending result was consumed on this edge
                     outValid <= 1'b0;
                  end else begin
                     result    <= ld_res;
                     zeroFlag  <= (ld_res == '0);
                     carryFlag <= ld_carry;
                     ovfFlag   <= ld_ovf;
                     negFlag   <= ld_res[WIDTH-1];
                     outValid  <= 1'b1;
                  end
               end else if (outValid && outReady) begin
                  outValid <= 1'b0;
               end
            end
            BUSY: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  result    <= ld_res;
                  zeroFlag  <= (ld_res == '0);
                  carryFlag <= ld_carry;
                  ovfFlag   <= ld_ovf;
                  negFlag   <= ld_res[WIDTH-1];
                  outValid  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
// tb_alu_pipe: directed tests for an 8-bit multiplier instance and a 16-bit
// instance without multiplier. Flags are compared as {valid,zero,carry,ovf,neg}.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [2:0]  fun8 = 3'b000;
   logic [7:0]  a8 = 8'h00;
   logic [7:0]  b8 = 8'h00;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [7:0]  res8;
   logic        z8, c8, v8, n8;

   logic        in_valid16 = 1'b0;
   logic        in_ready16;
   logic [2:0]  fun16 = 3'b000;
   logic [15:0] a16 = 16'h0000;
   logic [15:0] b16 = 16'h0000;
   logic        out_valid16;
   logic        out_ready16 = 1'b1;
   logic [15:0] res16;
   logic        z16, c16, v16, n16;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) u_dut8 (
      .clk(clk), .rstN(rst_n),
      .inValid(in_valid8), .inReady(in_ready8),
      .funSel(fun8), .a(a8), .b(b8),
      .outValid(out_valid8), .outReady(out_ready8),
      .result(res8), .zeroFlag(z8), .carryFlag(c8), .ovfFlag(v8), .negFlag(n8)
   );

   alu_pipe #(.WIDTH(16), .MUL_EN(1'b0)) u_dut16 (
      .clk(clk), .rstN(rst_n),
      .inValid(in_valid16), .inReady(in_ready16),
      .funSel(fun16), .a(a16), .b(b16),
      .outValid(out_valid16), .outReady(out_ready16),
      .result(res16), .zeroFlag(z16), .carryFlag(c16), .ovfFlag(v16), .negFlag(n16)
   );

   // Offer one operation to the 8-bit instance; returns 1 edge after acceptance (+1).
   task automatic send8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      bit ok;
      ok = 1'b0;
      fun8 = op; a8 = x; b8 = y; in_valid8 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready8) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid8 = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL accept8 op=%b inReady never high got %b want 1", op, ok);
      end
   endtask

   task automatic send16(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
      bit ok;
      ok = 1'b0;
      fun16 = op; a16 = x; b16 = y; in_valid16 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready16) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid16 = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL accept16 op=%b inReady never high got %b want 1", op, ok);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({out_valid8, res8, z8, c8, v8, n8, in_ready8} !== 14'h0) begin
         miscompares++;
         $display("FAIL reset8 got v=%b r=%h flags=%b rdy=%b want all 0",
                  out_valid8, res8, {z8, c8, v8, n8}, in_ready8);
      end
      vectors++;
      if ({out_valid16, res16, z16, c16, v16, n16, in_ready16} !== 22'h0) begin
         miscompares++;
         $display("FAIL reset16 got v=%b r=%h flags=%b rdy=%b want all 0",
                  out_valid16, res16, {z16, c16, v16, n16}, in_ready16);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (in_ready8 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release inReady got %b want 1", in_ready8);
      end
   endtask

   task automatic test_add_sub();
      send8(3'b010, 8'hFF, 8'h01);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h00, 5'b11100}) begin
         miscompares++;
         $display("FAIL add_ff_01 got %h/%b want 00/11100", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b010, 8'h7F, 8'h01);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h80, 5'b10011}) begin
         miscompares++;
         $display("FAIL add_7f_01 got %h/%b want 80/10011", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b011, 8'h80, 8'h01);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h7F, 5'b10010}) begin
         miscompares++;
         $display("FAIL sub_80_01 got %h/%b want 7f/10010", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b011, 8'h01, 8'h02);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'hFF, 5'b10101}) begin
         miscompares++;
         $display("FAIL sub_01_02 got %h/%b want ff/10101", res8, {out_valid8, z8, c8, v8, n8});
      end
   endtask

   task automatic test_logic_slt();
      send8(3'b100, 8'hF0, 8'h3C);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'hCC, 5'b10001}) begin
         miscompares++;
         $display("FAIL xor got %h/%b want cc/10001", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b101, 8'hF0, 8'h0C);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h03, 5'b10000}) begin
         miscompares++;
         $display("FAIL nor got %h/%b want 03/10000", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b111, 8'hFE, 8'h04);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h01, 5'b10000}) begin
         miscompares++;
         $display("FAIL slt_fe_04 got %h/%b want 01/10000", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b111, 8'h04, 8'hFE);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h00, 5'b11000}) begin
         miscompares++;
         $display("FAIL slt_04_fe got %h/%b want 00/11000", res8, {out_valid8, z8, c8, v8, n8});
      end
   endtask

   task automatic test_mul();
      out_ready8 = 1'b1;
      send8(3'b110, 8'h0F, 8'h11);
      // inputs change after acceptance and must be ignored
      fun8 = 3'b000; a8 = 8'h55; b8 = 8'h00;
      for (int k = 1; k <= 8; k++) begin
         vectors++;
         if ({out_valid8, in_ready8} !== 2'b00) begin
            miscompares++;
            $display("FAIL mul_busy k=%0d got v=%b rdy=%b want 0 0", k, out_valid8, in_ready8);
         end
         @(posedge clk); #1;
      end
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'hFF, 5'b10001}) begin
         miscompares++;
         $display("FAIL mul_0f_11 got %h/%b want ff/10001", res8, {out_valid8, z8, c8, v8, n8});
      end
      send8(3'b110, 8'h10, 8'h10);
      repeat (8) @(posedge clk);
      #1;
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h00, 5'b11010}) begin
         miscompares++;
         $display("FAIL mul_10_10 got %h/%b want 00/11010", res8, {out_valid8, z8, c8, v8, n8});
      end
   endtask

   task automatic test_backpressure();
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      send8(3'b000, 8'hCC, 8'hAA);
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'h88, 5'b10001}) begin
         miscompares++;
         $display("FAIL bp_and got %h/%b want 88/10001", res8, {out_valid8, z8, c8, v8, n8});
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         vectors++;
         if ({res8, out_valid8, in_ready8} !== {8'h88, 2'b10}) begin
            miscompares++;
            $display("FAIL bp_hold k=%0d got r=%h v=%b rdy=%b want 88 1 0", k, res8, out_valid8, in_ready8);
         end
      end
      fun8 = 3'b001; a8 = 8'hCC; b8 = 8'hAA; in_valid8 = 1'b1;
      out_ready8 = 1'b1;
      #1;
      vectors++;
      if (in_ready8 !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release inReady got %b want 1", in_ready8);
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      vectors++;
      if ({res8, out_valid8, z8, c8, v8, n8} !== {8'hEE, 5'b10001}) begin
         miscompares++;
         $display("FAIL bp_or got %h/%b want ee/10001", res8, {out_valid8, z8, c8, v8, n8});
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid8 !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_drain outValid got %b want 0", out_valid8);
      end
   endtask

   task automatic test_reset_mid_mul();
      out_ready8 = 1'b1;
      send8(3'b001, 8'h0F, 8'h30);
      send8(3'b110, 8'h0F, 8'h11);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid8, res8, z8, c8, v8, n8, in_ready8} !== 14'h0) begin
         miscompares++;
         $display("FAIL async_reset got v=%b r=%h flags=%b rdy=%b want all 0",
                  out_valid8, res8, {z8, c8, v8, n8}, in_ready8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (in_ready8 !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset inReady got %b want 1", in_ready8);
      end
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (out_valid8 !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_result k=%0d outValid got %b want 0", k, out_valid8);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] xa [4];
      logic [7:0] xb [4];
      logic [7:0] er [4];
      logic [4:0] ef [4];
      xa = '{8'h01, 8'h10, 8'hFF, 8'h80};
      xb = '{8'h02, 8'h20, 8'hFF, 8'h80};
      er = '{8'h03, 8'h30, 8'hFE, 8'h00};
      ef = '{5'b10000, 5'b10000, 5'b10101, 5'b11110};
      out_ready8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fun8 = 3'b010; a8 = xa[i]; b8 = xb[i]; in_valid8 = 1'b1;
         vectors++;
         if (in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_ready i=%0d got %b want 1", i, in_ready8);
         end
         @(posedge clk); #1;
         vectors++;
         if ({res8, out_valid8, z8, c8, v8, n8} !== {er[i], ef[i]}) begin
            miscompares++;
            $display("FAIL stream i=%0d got %h/%b want %h/%b", i, res8,
                     {out_valid8, z8, c8, v8, n8}, er[i], ef[i]);
         end
      end
      in_valid8 = 1'b0;
   endtask

   task automatic test_wide_nomul();
      out_ready16 = 1'b1;
      send16(3'b010, 16'h7FFF, 16'h0001);
      vectors++;
      if ({res16, out_valid16, z16, c16, v16, n16} !== {16'h8000, 5'b10011}) begin
         miscompares++;
         $display("FAIL w16_add got %h/%b want 8000/10011", res16, {out_valid16, z16, c16, v16, n16});
      end
      send16(3'b110, 16'h1234, 16'h5678);
      vectors++;
      if ({res16, out_valid16, z16, c16, v16, n16} !== {16'h0000, 5'b11000}) begin
         miscompares++;
         $display("FAIL w16_op110 got %h/%b want 0000/11000", res16, {out_valid16, z16, c16, v16, n16});
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic_slt();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_back_to_back();
      test_wide_nomul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
